wb_master: RTL and testbench

//  Single-outstanding bus initiator for the strobe/ack memory bus (we, strb, addr, wdata, rdata, ack).

---
 rtl/wb_master_if.sv | 31 +++
 rtl/wb_master.sv | 128 ++++++++++++
 tb/tb_wb_master.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_master_if.sv
// Client command/response and strobe/ack bus signals of the single-outstanding bus initiator.
// master: the initiator's view; slave: the client plus bus responder that surround it.
interface wb_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              strb;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rdata, ack,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, strb, we, addr, wdata
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rdata, ack,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, strb, we, addr, wdata
  );
endinterface

// File: rtl/wb_master.sv
// Single-outstanding strobe/ack bus initiator; optional REQ abort via WB_MASTER_TIMEOUT_EN.
// Latency: strb the cycle after accept, rsp_valid the cycle after ack; cmd_ready low from accept until the post-DONE idle.
module wb_master #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  wb_master_if.master bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              strb_q, strb_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_err_q, rsp_err_d;
`else
  // Timeout length has no effect when REQ waits indefinitely.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d     = state_q;
    strb_d      = strb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef WB_MASTER_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          we_d    = bus.cmd_we;
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          strb_d  = 1'b1;
          state_d = ST_REQ;
`ifdef WB_MASTER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_REQ: begin
        // Ack beats the timeout when both land on the same cycle.
        if (bus.ack) begin
          strb_d      = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? '0 : bus.rdata;
          state_d     = ST_DONE;
`ifdef WB_MASTER_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          strb_d      = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      strb_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      strb_q      <= strb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef WB_MASTER_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE) && !rst;
  assign bus.strb      = strb_q;
  assign bus.we        = we_q;
  assign bus.addr      = addr_q;
  assign bus.wdata     = wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
`ifdef WB_MASTER_TIMEOUT_EN
  assign bus.rsp_err   = rsp_err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_master.sv
// Directed bench for wb_master: client stimulus, a responder with programmable ack delay, and bus/response monitors.
module tb_wb_master;
  logic clk;
  logic rst;

  wb_master_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  wb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Responder: ack D cycles after strb rises (D=0 never acks), plus a forced stray ack.
  int         resp_d;
  logic       force_ack;
  int         scnt;
  logic [7:0] mem [256];

  always @(posedge clk) begin
    if (rst || !bus.strb) scnt <= 0;
    else                  scnt <= scnt + 1;
    if (bus.strb && bus.ack && bus.we) mem[bus.addr] <= bus.wdata;
  end

  assign bus.ack   = force_ack || (bus.strb && (resp_d > 0) && (scnt == resp_d - 1));
  assign bus.rdata = mem[bus.addr];

  // Monitors: completed bus transfers, responses, strb rising edges.
  logic [16:0] bus_q[$];
  logic [8:0]  rsp_q[$];
  int          rises = 0;
  logic        strb_prev = 1'b0;

  always @(posedge clk) begin
    if (!rst && bus.strb && bus.ack) bus_q.push_back({bus.we, bus.addr, bus.wdata});
    if (bus.rsp_valid) rsp_q.push_back({bus.rsp_err, bus.rsp_rdata});
    if (bus.strb && !strb_prev) rises <= rises + 1;
    strb_prev <= bus.strb;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_cmd(input logic w, input logic [7:0] a, input logic [7:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
  endtask

  logic [16:0] cmds [4];
  logic [8:0]  exp_rsp [4];
  int          bus_base, rsp_base, rise_base, waited;

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    force_ack = 1'b0;
    resp_d    = 1;
    tick();
    tick();

    // Reset state
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_strb", bus.strb, 0);
    check("rst_we", bus.we, 0);
    check("rst_addr", bus.addr, 0);
    check("rst_wdata", bus.wdata, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    rst = 1'b0;
    #1;
    check("idle_cmd_ready", bus.cmd_ready, 1);

    // 1. Write 0xA5 to 0x3C, D=1
    drive_cmd(1'b1, 8'h3C, 8'hA5);
    tick();
    bus.cmd_valid = 1'b0;
    check("wr_strb", bus.strb, 1);
    check("wr_we", bus.we, 1);
    check("wr_addr", bus.addr, 8'h3C);
    check("wr_wdata", bus.wdata, 8'hA5);
    check("wr_busy", bus.cmd_ready, 0);
    tick();
    check("wr_rsp_valid", bus.rsp_valid, 1);
    check("wr_rsp_rdata", bus.rsp_rdata, 0);
    check("wr_rsp_err", bus.rsp_err, 0);
    check("wr_strb_gap", bus.strb, 0);
    check("wr_done_busy", bus.cmd_ready, 0);
    tick();
    check("wr_rsp_pulse", bus.rsp_valid, 0);
    check("wr_ready_back", bus.cmd_ready, 1);
    check("wr_addr_hold", bus.addr, 8'h3C);
    check("wr_we_hold", bus.we, 1);

    // 2. Read back 0x3C, D=1
    drive_cmd(1'b0, 8'h3C, 8'h00);
    tick();
    bus.cmd_valid = 1'b0;
    check("rd_strb", bus.strb, 1);
    check("rd_we", bus.we, 0);
    tick();
    check("rd_rsp_valid", bus.rsp_valid, 1);
    check("rd_rsp_rdata", bus.rsp_rdata, 8'hA5);
    check("rd_rsp_err", bus.rsp_err, 0);
    check("rd_m1_busy", bus.cmd_ready, 0);
    tick();
    check("rd_m2_ready", bus.cmd_ready, 1);
    check("rd_rdata_hold", bus.rsp_rdata, 8'hA5);

    // 3. Back-to-back with cmd_valid held high
    cmds[0] = {1'b1, 8'h10, 8'h11};
    cmds[1] = {1'b1, 8'h11, 8'h22};
    cmds[2] = {1'b0, 8'h10, 8'h00};
    cmds[3] = {1'b0, 8'h11, 8'h00};
    exp_rsp[0] = {1'b0, 8'h00};
    exp_rsp[1] = {1'b0, 8'h00};
    exp_rsp[2] = {1'b0, 8'h11};
    exp_rsp[3] = {1'b0, 8'h22};
    bus_base  = bus_q.size();
    rsp_base  = rsp_q.size();
    rise_base = rises;
    for (int k = 0; k < 4; k++) begin
      drive_cmd(cmds[k][16], cmds[k][15:8], cmds[k][7:0]);
      waited = 0;
      while (!bus.cmd_ready && waited < 20) begin
        tick();
        waited++;
      end
      check("b2b_ready", bus.cmd_ready, 1);
      tick();
    end
    bus.cmd_valid = 1'b0;
    waited = 0;
    while (rsp_q.size() < rsp_base + 4 && waited < 20) begin
      tick();
      waited++;
    end
    tick();
    tick();
    check("b2b_rsp_count", rsp_q.size() - rsp_base, 4);
    check("b2b_bus_count", bus_q.size() - bus_base, 4);
    check("b2b_strb_rises", rises - rise_base, 4);
    for (int k = 0; k < 4; k++) begin
      if (bus_base + k < bus_q.size()) check("b2b_bus_cmd", bus_q[bus_base + k], cmds[k]);
      else check("b2b_bus_cmd_missing", 0, 1);
      if (rsp_base + k < rsp_q.size()) check("b2b_rsp", rsp_q[rsp_base + k], exp_rsp[k]);
      else check("b2b_rsp_missing", 0, 1);
    end

    // 4. Stalled read, D=5, then a stray ack while idle
    resp_d = 5;
    drive_cmd(1'b0, 8'h11, 8'h00);
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_strb", bus.strb, 1);
      check("stall_addr", bus.addr, 8'h11);
      check("stall_we", bus.we, 0);
      check("stall_no_rsp", bus.rsp_valid, 0);
      tick();
    end
    check("stall_rsp_valid", bus.rsp_valid, 1);
    check("stall_rsp_rdata", bus.rsp_rdata, 8'h22);
    check("stall_strb_low", bus.strb, 0);
    tick();
    rsp_base = rsp_q.size();
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    check("stray_no_rsp", bus.rsp_valid, 0);
    check("stray_strb", bus.strb, 0);
    tick();
    check("stray_no_rsp2", bus.rsp_valid, 0);
    check("stray_rsp_count", rsp_q.size() - rsp_base, 0);

    // 5. Reset while REQ is waiting
    resp_d = 0;
    drive_cmd(1'b1, 8'h50, 8'h77);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    check("mid_strb_up", bus.strb, 1);
    rsp_base = rsp_q.size();
    rst = 1'b1;
    tick();
    check("mid_rst_strb", bus.strb, 0);
    check("mid_rst_rsp", bus.rsp_valid, 0);
    rst = 1'b0;
    tick();
    check("mid_rel_rsp", bus.rsp_valid, 0);
    check("mid_rel_ready", bus.cmd_ready, 1);
    check("mid_rsp_count", rsp_q.size() - rsp_base, 0);
    resp_d   = 1;
    bus_base = bus_q.size();
    drive_cmd(1'b1, 8'h01, 8'h5A);
    tick();
    bus.cmd_valid = 1'b0;
    check("post_strb", bus.strb, 1);
    check("post_addr", bus.addr, 8'h01);
    tick();
    check("post_rsp_valid", bus.rsp_valid, 1);
    check("post_rsp_err", bus.rsp_err, 0);
    check("post_rsp_rdata", bus.rsp_rdata, 0);
    if (bus_base < bus_q.size()) check("post_bus_cmd", bus_q[bus_base], {1'b1, 8'h01, 8'h5A});
    else check("post_bus_cmd_missing", 0, 1);
    tick();

`ifdef WB_MASTER_TIMEOUT_EN
    // 6a. No ack: abort after 16 REQ cycles
    resp_d = 0;
    drive_cmd(1'b0, 8'h3C, 8'h00);
    tick();
    bus.cmd_valid = 1'b0;
    repeat (15) tick();
    check("to_strb_c16", bus.strb, 1);
    check("to_no_rsp_c16", bus.rsp_valid, 0);
    tick();
    check("to_strb_fall", bus.strb, 0);
    check("to_rsp_valid", bus.rsp_valid, 1);
    check("to_rsp_err", bus.rsp_err, 1);
    check("to_rsp_rdata", bus.rsp_rdata, 0);
    tick();
    tick();
    check("to_err_hold", bus.rsp_err, 1);

    // 6b. Ack on the 16th REQ cycle wins
    resp_d = 16;
    drive_cmd(1'b0, 8'h3C, 8'h00);
    tick();
    bus.cmd_valid = 1'b0;
    repeat (16) tick();
    check("to_ack_rsp_valid", bus.rsp_valid, 1);
    check("to_ack_rsp_err", bus.rsp_err, 0);
    check("to_ack_rsp_rdata", bus.rsp_rdata, 8'hA5);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
